// File: rtl/regfile_sb_pkg.sv
// Shared defaults and legal parameter ranges for the scoreboarded register file.
package regfile_sb_pkg;

  localparam int XLEN_DEFAULT      = 32;
  localparam int REG_NUM_DEFAULT   = 32;
  localparam int ADDR_SIZE_DEFAULT = 5;
  localparam int N_RD_DEFAULT      = 3;

  localparam int N_RD_MIN = 1;
  localparam int N_RD_MAX = 4;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-writeback bit per register plus a registered popcount of those bits.
module regfile_scoreboard #(
  parameter int REG_NUM   = 32,
  parameter int ADDR_SIZE = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_en,
  input  logic [ADDR_SIZE-1:0] set_rd,
  input  logic                 clr_en,
  input  logic [ADDR_SIZE-1:0] clr_rd,
  input  logic                 flush,
  output logic [REG_NUM-1:0]   pending,
  output logic [ADDR_SIZE:0]   pend_cnt
);

  localparam int CW = ADDR_SIZE + 1;

  logic [REG_NUM-1:0] pend_next;
  logic [CW-1:0]      cnt_next;

  function automatic logic tracked(input logic [ADDR_SIZE-1:0] a);
    return (a != '0) && (int'(a) < REG_NUM);
  endfunction

  // Clear first so a same-cycle set wins; flush overrides both.
  always_comb begin
    pend_next = pending;
    if (clr_en && tracked(clr_rd)) pend_next[clr_rd] = 1'b0;
    if (set_en && tracked(set_rd)) pend_next[set_rd] = 1'b1;
    if (flush) pend_next = '0;
    cnt_next = '0;
    for (int i = 0; i < REG_NUM; i++) cnt_next = cnt_next + CW'(pend_next[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= '0;
      pend_cnt <= '0;
    end else begin
      pending  <= pend_next;
      pend_cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write-through bypass and a pending-writeback
// scoreboard that stalls issue on unready sources or busy destinations.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int XLEN      = XLEN_DEFAULT,
  parameter int REG_NUM   = REG_NUM_DEFAULT,
  parameter int ADDR_SIZE = ADDR_SIZE_DEFAULT,
  parameter int N_RD      = N_RD_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_RD*ADDR_SIZE-1:0] rd_addr,
  output logic [N_RD*XLEN-1:0]      rd_data,
  output logic [N_RD-1:0]           rd_ready,
  input  logic                      issue_valid,
  input  logic [N_RD-1:0]           issue_src,
  input  logic                      issue_we,
  input  logic [ADDR_SIZE-1:0]      issue_rd,
  output logic                      issue_stall,
  input  logic                      wb_we,
  input  logic [ADDR_SIZE-1:0]      wb_rd,
  input  logic [XLEN-1:0]           wb_data,
  input  logic                      flush,
  output logic [ADDR_SIZE:0]        pend_cnt
);

  if (N_RD < N_RD_MIN || N_RD > N_RD_MAX || REG_NUM > (2 ** ADDR_SIZE)) begin : g_bad_params
    $error("regfile_sb: illegal N_RD / REG_NUM / ADDR_SIZE combination");
  end

  logic [XLEN-1:0]    regs [REG_NUM];
  logic [REG_NUM-1:0] pending;
  logic               src_block;
  logic               dest_block;
  logic               set_en;

  function automatic logic valid_reg(input logic [ADDR_SIZE-1:0] a);
    return (a != '0) && (int'(a) < REG_NUM);
  endfunction

  function automatic logic pend_of(input logic [ADDR_SIZE-1:0] a);
    return valid_reg(a) ? pending[a] : 1'b0;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
    end else if (wb_we && valid_reg(wb_rd)) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // Bypass is masked during reset so every read is zero while rst is high.
  for (genvar k = 0; k < N_RD; k++) begin : g_rd
    logic [ADDR_SIZE-1:0] addr;
    logic                 bypass;
    assign addr   = rd_addr[k*ADDR_SIZE +: ADDR_SIZE];
    assign bypass = !rst && wb_we && valid_reg(addr) && (wb_rd == addr);
    assign rd_data[k*XLEN +: XLEN] = bypass ? wb_data
                                   : (valid_reg(addr) ? regs[addr] : '0);
    assign rd_ready[k] = !pend_of(addr) || bypass;
  end

  assign src_block   = |(issue_src & ~rd_ready);
  assign dest_block  = issue_we && pend_of(issue_rd) && !(wb_we && (wb_rd == issue_rd));
  assign issue_stall = issue_valid && (flush || src_block || dest_block);
  assign set_en      = issue_valid && !issue_stall && issue_we;

  regfile_scoreboard #(
    .REG_NUM  (REG_NUM),
    .ADDR_SIZE(ADDR_SIZE)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .set_en  (set_en),
    .set_rd  (issue_rd),
    .clr_en  (wb_we),
    .clr_rd  (wb_rd),
    .flush   (flush),
    .pending (pending),
    .pend_cnt(pend_cnt)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: bypass, scoreboard stalls, flush and async reset.
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int AS   = 5;
  localparam int NRD  = 3;

  logic                clk;
  logic                rst;
  logic [NRD*AS-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_ready;
  logic                issue_valid;
  logic [NRD-1:0]      issue_src;
  logic                issue_we;
  logic [AS-1:0]       issue_rd;
  logic                issue_stall;
  logic                wb_we;
  logic [AS-1:0]       wb_rd;
  logic [XLEN-1:0]     wb_data;
  logic                flush;
  logic [AS:0]         pend_cnt;

  int tests;
  int failed;

  regfile_sb dut (
    .clk        (clk),
    .rst        (rst),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_ready   (rd_ready),
    .issue_valid(issue_valid),
    .issue_src  (issue_src),
    .issue_we   (issue_we),
    .issue_rd   (issue_rd),
    .issue_stall(issue_stall),
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .flush      (flush),
    .pend_cnt   (pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [NRD*AS-1:0] pack(input logic [AS-1:0] a0,
                                             input logic [AS-1:0] a1,
                                             input logic [AS-1:0] a2);
    return {a2, a1, a0};
  endfunction

  task automatic checkOutput(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [NRD-1:0] isrc, input logic iwe,
                               input logic [AS-1:0] ird, input logic wwe, input logic [AS-1:0] wrd,
                               input logic [XLEN-1:0] wdt, input logic fl,
                               input logic [NRD*AS-1:0] ra);
    issue_valid = iv;
    issue_src   = isrc;
    issue_we    = iwe;
    issue_rd    = ird;
    wb_we       = wwe;
    wb_rd       = wrd;
    wb_data     = wdt;
    flush       = fl;
    rd_addr     = ra;
  endtask

  task automatic edgeThenSettle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst    = 1'b1;
    applyStimulus(0, 3'b000, 0, 5'd0, 0, 5'd0, 32'h0, 0, pack(5'd0, 5'd0, 5'd0));
    #2;
    checkOutput("reset_cnt", 96'(pend_cnt), 96'd0);
    checkOutput("reset_rdata", 96'(rd_data), 96'd0);
    checkOutput("reset_ready", 96'(rd_ready), 96'b111);

    // Write r5, then read it on every port.
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 3'b000, 0, 5'd0, 1, 5'd5, 32'h1234, 0, pack(5'd0, 5'd0, 5'd0));
    edgeThenSettle();
    @(negedge clk);
    applyStimulus(0, 3'b000, 0, 5'd0, 0, 5'd0, 32'h0, 0, pack(5'd5, 5'd5, 5'd5));
    #1;
    checkOutput("r5_all_ports", 96'(rd_data), {32'h1234, 32'h1234, 32'h1234});
    checkOutput("r5_ready", 96'(rd_ready), 96'b111);

    // Same-cycle bypass on port 0.
    @(negedge clk);
    applyStimulus(0, 3'b000, 0, 5'd0, 1, 5'd7, 32'hABCD, 0, pack(5'd7, 5'd5, 5'd0));
    #1;
    checkOutput("bypass_r7", 96'(rd_data[31:0]), 96'hABCD);
    checkOutput("port1_r5", 96'(rd_data[63:32]), 96'h1234);
    edgeThenSettle();
    @(negedge clk);
    applyStimulus(0, 3'b000, 0, 5'd0, 1, 5'd0, 32'hFFFF, 0, pack(5'd7, 5'd0, 5'd0));
    #1;
    checkOutput("r7_stored", 96'(rd_data[31:0]), 96'hABCD);
    checkOutput("r0_no_bypass", 96'(rd_data[63:32]), 96'h0);
    edgeThenSettle();
    checkOutput("r0_after_write", 96'(rd_data[63:32]), 96'h0);

    // Issue r3 as destination, then a consumer of r3 stalls until its writeback.
    @(negedge clk);
    applyStimulus(1, 3'b000, 1, 5'd3, 0, 5'd0, 32'h0, 0, pack(5'd3, 5'd0, 5'd0));
    #1;
    checkOutput("issue_r3_accept", 96'(issue_stall), 96'd0);
    edgeThenSettle();
    checkOutput("cnt_r3", 96'(pend_cnt), 96'd1);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      applyStimulus(1, 3'b001, 0, 5'd0, 0, 5'd0, 32'h0, 0, pack(5'd3, 5'd0, 5'd0));
      #1;
      checkOutput("raw_stall", 96'(issue_stall), 96'd1);
      checkOutput("raw_notready", 96'(rd_ready[0]), 96'd0);
      edgeThenSettle();
      checkOutput("raw_cnt_hold", 96'(pend_cnt), 96'd1);
    end
    @(negedge clk);
    applyStimulus(1, 3'b001, 0, 5'd0, 1, 5'd3, 32'h33, 0, pack(5'd3, 5'd0, 5'd0));
    #1;
    checkOutput("raw_wb_accept", 96'(issue_stall), 96'd0);
    checkOutput("raw_wb_data", 96'(rd_data[31:0]), 96'h33);
    edgeThenSettle();
    checkOutput("raw_cnt_clear", 96'(pend_cnt), 96'd0);

    // r9 pending, WAW stall, then issue+writeback to r9 in one cycle.
    @(negedge clk);
    applyStimulus(1, 3'b000, 1, 5'd9, 0, 5'd0, 32'h0, 0, pack(5'd9, 5'd0, 5'd0));
    edgeThenSettle();
    checkOutput("cnt_r9", 96'(pend_cnt), 96'd1);
    @(negedge clk);
    applyStimulus(1, 3'b000, 1, 5'd9, 0, 5'd0, 32'h0, 0, pack(5'd9, 5'd0, 5'd0));
    #1;
    checkOutput("waw_stall", 96'(issue_stall), 96'd1);
    @(negedge clk);
    applyStimulus(1, 3'b000, 1, 5'd9, 1, 5'd9, 32'h99, 0, pack(5'd9, 5'd0, 5'd0));
    #1;
    checkOutput("waw_wb_accept", 96'(issue_stall), 96'd0);
    edgeThenSettle();
    checkOutput("set_wins_cnt", 96'(pend_cnt), 96'd1);
    @(negedge clk);
    applyStimulus(0, 3'b000, 0, 5'd0, 0, 5'd0, 32'h0, 0, pack(5'd9, 5'd0, 5'd0));
    #1;
    checkOutput("r9_still_pending", 96'(rd_ready[0]), 96'd0);
    checkOutput("r9_data", 96'(rd_data[31:0]), 96'h99);
    applyStimulus(0, 3'b000, 0, 5'd0, 1, 5'd9, 32'h98, 0, pack(5'd9, 5'd0, 5'd0));
    edgeThenSettle();
    checkOutput("r9_cleared", 96'(pend_cnt), 96'd0);

    // r1, r2, r4 pending, then flush with a same-cycle issue to r6 and writeback to r1.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      applyStimulus(1, 3'b000, 1, (i == 2) ? 5'd4 : 5'(i + 1), 0, 5'd0, 32'h0, 0,
                    pack(5'd0, 5'd0, 5'd0));
      edgeThenSettle();
    end
    checkOutput("cnt_three", 96'(pend_cnt), 96'd3);
    @(negedge clk);
    applyStimulus(1, 3'b000, 1, 5'd6, 1, 5'd1, 32'h11, 1, pack(5'd6, 5'd1, 5'd0));
    #1;
    checkOutput("flush_stall", 96'(issue_stall), 96'd1);
    edgeThenSettle();
    checkOutput("flush_cnt", 96'(pend_cnt), 96'd0);
    @(negedge clk);
    applyStimulus(0, 3'b000, 0, 5'd0, 0, 5'd0, 32'h0, 0, pack(5'd6, 5'd1, 5'd2));
    #1;
    checkOutput("flush_ready", 96'(rd_ready), 96'b111);
    checkOutput("flush_wb_data", 96'(rd_data[63:32]), 96'h11);

    // Mid-stream async reset with three pending registers.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      applyStimulus(1, 3'b000, 1, (i == 2) ? 5'd4 : 5'(i + 1), 0, 5'd0, 32'h0, 0,
                    pack(5'd0, 5'd0, 5'd0));
      edgeThenSettle();
    end
    checkOutput("pre_rst_cnt", 96'(pend_cnt), 96'd3);
    @(negedge clk);
    applyStimulus(0, 3'b000, 0, 5'd0, 0, 5'd0, 32'h0, 0, pack(5'd5, 5'd7, 5'd1));
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_cnt", 96'(pend_cnt), 96'd0);
    checkOutput("async_rst_rdata", 96'(rd_data), 96'd0);
    checkOutput("async_rst_ready", 96'(rd_ready), 96'b111);

    // Issue in the cycle reset releases takes effect at the next edge.
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1, 3'b000, 1, 5'd2, 0, 5'd0, 32'h0, 0, pack(5'd5, 5'd0, 5'd0));
    edgeThenSettle();
    checkOutput("post_rst_issue", 96'(pend_cnt), 96'd1);
    checkOutput("post_rst_r5", 96'(rd_data[31:0]), 96'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
